// File: rtl/gam_mem_initiator.sv
// gam_mem_initiator
// Initiator side of the GAM memory-layer control bundle. Takes node-level
// requests (READ, WRITE, SCAN, INC_M) over a valid/ready handshake, drives
// registered address/data/strobes towards the memory layer and returns read
// data on a registered valid/ready response channel.
//
// Build option: define GAM_MEM_SCAN_EN to compile in the SCAN operation and
// its node counter. Without it, a SCAN request is answered with rsp_err=1.
module gam_mem_initiator #(
    parameter int          NUM_CLASSES = 16,
    parameter int          NUM_NODES   = 32,
    parameter logic [31:0] M_MAX       = 32'h7FFF_FFFF,
    parameter int          VEC_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    // request channel
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [31:0]      req_class,
    input  logic [31:0]      req_node,
    input  logic [4:0]       req_fields,
    input  logic [VEC_W-1:0] req_X,
    input  logic [VEC_W-1:0] req_W,
    input  logic [31:0]      req_Th,
    input  logic [31:0]      req_M,
    // memory-layer drive
    output logic [31:0]      mem_class,
    output logic [31:0]      mem_node,
    output logic [31:0]      mem_Th,
    output logic [31:0]      mem_M,
    output logic [VEC_W-1:0] mem_X,
    output logic [VEC_W-1:0] mem_W,
    output logic             mem_X_c,
    output logic             mem_C_c,
    output logic             mem_W_c,
    output logic             mem_T_c,
    output logic             mem_M_c,
    output logic             mem_RD_WR,
    // memory-layer read data
    input  logic [31:0]      mem_rd_class,
    input  logic [31:0]      mem_rd_Th,
    input  logic [31:0]      mem_rd_M,
    input  logic [VEC_W-1:0] mem_rd_X,
    input  logic [VEC_W-1:0] mem_rd_W,
    // response channel
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_class,
    output logic [31:0]      rsp_node,
    output logic [31:0]      rsp_Th,
    output logic [31:0]      rsp_M,
    output logic [VEC_W-1:0] rsp_X,
    output logic [VEC_W-1:0] rsp_W,
    output logic             rsp_last,
    output logic             rsp_err
);

    localparam logic [1:0] OP_READ  = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_SCAN  = 2'd2;
    localparam logic [1:0] OP_INC_M = 2'd3;

    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;

    localparam logic [31:0]      ZERO32  = 32'd0;
    localparam logic [VEC_W-1:0] ZEROVEC = {VEC_W{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_RMW_WR = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t      state_r;
    state_t      next_state_s;
    logic [1:0]  op_r;
    logic [4:0]  fields_r;

    logic        op_ok_s;
    logic        idx_err_s;
    logic [4:0]  req_mask_s;
    logic [4:0]  issue_mask_s;
    logic        issue_wr_s;
    logic [31:0] sat_m_s;
    logic        accept_s;
    logic        rsp_hs_s;

    // Saturating M increment: never exceeds M_MAX, never wraps.
    function automatic logic [31:0] sat_inc(input logic [31:0] m);
        logic [31:0] r;
        if (m >= M_MAX) begin
            r = M_MAX;
        end else begin
            r = m + 32'd1;
        end
        return r;
    endfunction

    // Request decode: legality of the op/indices and the effective strobe mask.
    always_comb begin
        op_ok_s    = 1'b1;
        idx_err_s  = 1'b0;
        req_mask_s = req_fields;
`ifdef GAM_MEM_SCAN_EN
        op_ok_s = 1'b1;
`else
        if (req_op == OP_SCAN) begin
            op_ok_s = 1'b0;
        end else begin
            op_ok_s = 1'b1;
        end
`endif
        if (!op_ok_s || (req_class >= 32'(NUM_CLASSES))) begin
            idx_err_s = 1'b1;
        end else if ((req_op != OP_SCAN) && (req_node >= 32'(NUM_NODES))) begin
            idx_err_s = 1'b1;
        end else begin
            idx_err_s = 1'b0;
        end
        // INC_M touches the M field only, whatever mask came with it
        if (req_op == OP_INC_M) begin
            req_mask_s = 5'b00001;
        end else begin
            req_mask_s = req_fields;
        end
    end

    // Handshake qualifiers, the mask/direction of the next ISSUE cycle and the RMW value.
    always_comb begin
        accept_s     = req_valid && req_ready;
        rsp_hs_s     = rsp_valid && rsp_ready;
        issue_mask_s = fields_r;
        issue_wr_s   = 1'b0;
        if (state_r == ST_IDLE) begin
            issue_mask_s = req_mask_s;
            issue_wr_s   = (req_op == OP_WRITE);
        end else begin
            issue_mask_s = fields_r;
            issue_wr_s   = (op_r == OP_WRITE);
        end
        sat_m_s = sat_inc(mem_rd_M);
    end

    // Next-state logic of the request sequencer.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (idx_err_s) begin
                        next_state_s = ST_RESP;
                    end else begin
                        next_state_s = ST_ISSUE;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (op_r == OP_INC_M) begin
                    next_state_s = ST_RMW_WR;
                end else begin
                    next_state_s = ST_RESP;
                end
            end
            ST_RMW_WR: begin
                next_state_s = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_hs_s) begin
                    if (rsp_last) begin
                        next_state_s = ST_IDLE;
                    end else begin
                        next_state_s = ST_ISSUE;
                    end
                end else begin
                    next_state_s = ST_RESP;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // req_ready and the strobes/direction, registered from the next state so they are glitch-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready <= 1'b1;
            mem_X_c   <= 1'b0;
            mem_C_c   <= 1'b0;
            mem_W_c   <= 1'b0;
            mem_T_c   <= 1'b0;
            mem_M_c   <= 1'b0;
            mem_RD_WR <= MEM_READ;
        end else begin
            req_ready <= (next_state_s == ST_IDLE);
            mem_X_c   <= 1'b0;
            mem_C_c   <= 1'b0;
            mem_W_c   <= 1'b0;
            mem_T_c   <= 1'b0;
            mem_M_c   <= 1'b0;
            mem_RD_WR <= MEM_READ;
            case (next_state_s)
                ST_ISSUE: begin
                    {mem_X_c, mem_C_c, mem_W_c, mem_T_c, mem_M_c} <= issue_mask_s;
                    mem_RD_WR <= issue_wr_s ? MEM_WRITE : MEM_READ;
                end
                ST_RMW_WR: begin
                    mem_M_c   <= 1'b1;
                    mem_RD_WR <= MEM_WRITE;
                end
                default: begin
                    mem_RD_WR <= MEM_READ;
                end
            endcase
        end
    end

    // Latched request: op, mask, address and write data (also the scan node counter).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r      <= OP_READ;
            fields_r  <= 5'b00000;
            mem_class <= ZERO32;
            mem_node  <= ZERO32;
            mem_Th    <= ZERO32;
            mem_M     <= ZERO32;
            mem_X     <= ZEROVEC;
            mem_W     <= ZEROVEC;
        end else begin
            // rejected requests never load the address, so nothing out of range is driven
            if ((state_r == ST_IDLE) && accept_s && !idx_err_s) begin
                op_r      <= req_op;
                fields_r  <= req_mask_s;
                mem_class <= req_class;
                mem_node  <= (req_op == OP_SCAN) ? ZERO32 : req_node;
                mem_Th    <= req_Th;
                mem_M     <= req_M;
                mem_X     <= req_X;
                mem_W     <= req_W;
            end
            if (next_state_s == ST_RMW_WR) begin
                mem_M <= sat_m_s;
            end
`ifdef GAM_MEM_SCAN_EN
            if ((state_r == ST_RESP) && (next_state_s == ST_ISSUE)) begin
                mem_node <= mem_node + 32'd1;
            end
`endif
        end
    end

    // Response registers: built on entry to RESP, held until the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_last  <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_class <= ZERO32;
            rsp_node  <= ZERO32;
            rsp_Th    <= ZERO32;
            rsp_M     <= ZERO32;
            rsp_X     <= ZEROVEC;
            rsp_W     <= ZEROVEC;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (next_state_s == ST_RESP) begin
                        rsp_valid <= 1'b1;
                        rsp_last  <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_class <= ZERO32;
                        rsp_node  <= ZERO32;
                        rsp_Th    <= ZERO32;
                        rsp_M     <= ZERO32;
                        rsp_X     <= ZEROVEC;
                        rsp_W     <= ZEROVEC;
                    end
                end
                ST_ISSUE: begin
                    if (next_state_s == ST_RESP) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_node  <= mem_node;
                        rsp_last  <= (op_r == OP_SCAN) ? (mem_node == 32'(NUM_NODES - 1)) : 1'b1;
                        if (op_r == OP_WRITE) begin
                            rsp_X     <= ZEROVEC;
                            rsp_class <= ZERO32;
                            rsp_W     <= ZEROVEC;
                            rsp_Th    <= ZERO32;
                            rsp_M     <= ZERO32;
                        end else begin
                            rsp_X     <= fields_r[4] ? mem_rd_X     : ZEROVEC;
                            rsp_class <= fields_r[3] ? mem_rd_class : ZERO32;
                            rsp_W     <= fields_r[2] ? mem_rd_W     : ZEROVEC;
                            rsp_Th    <= fields_r[1] ? mem_rd_Th    : ZERO32;
                            rsp_M     <= fields_r[0] ? mem_rd_M     : ZERO32;
                        end
                    end
                end
                ST_RMW_WR: begin
                    // report the value actually written back
                    rsp_valid <= 1'b1;
                    rsp_last  <= 1'b1;
                    rsp_err   <= 1'b0;
                    rsp_node  <= mem_node;
                    rsp_class <= ZERO32;
                    rsp_Th    <= ZERO32;
                    rsp_M     <= mem_M;
                    rsp_X     <= ZEROVEC;
                    rsp_W     <= ZEROVEC;
                end
                ST_RESP: begin
                    if (rsp_hs_s) begin
                        rsp_valid <= 1'b0;
                        rsp_last  <= 1'b0;
                        rsp_err   <= 1'b0;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gam_mem_initiator.sv
// tb_gam_mem_initiator
// Directed bench for gam_mem_initiator with a behavioural memory layer and a
// response scoreboard. Expected responses are queued when a request is sent
// and compared when the response handshake occurs.
module tb_gam_mem_initiator;

    localparam int          NC    = 16;
    localparam int          NN    = 32;
    localparam logic [31:0] MMAX  = 32'h7FFF_FFFF;
    localparam int          VEC_W = 32;

    logic             clk;
    logic             rst_n;
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_op;
    logic [31:0]      req_class, req_node, req_Th, req_M;
    logic [4:0]       req_fields;
    logic [VEC_W-1:0] req_X, req_W;
    logic [31:0]      mem_class, mem_node, mem_Th, mem_M;
    logic [VEC_W-1:0] mem_X, mem_W;
    logic             mem_X_c, mem_C_c, mem_W_c, mem_T_c, mem_M_c, mem_RD_WR;
    logic [31:0]      mem_rd_class, mem_rd_Th, mem_rd_M;
    logic [VEC_W-1:0] mem_rd_X, mem_rd_W;
    logic             rsp_valid;
    logic             rsp_ready = 1'b1;
    logic [31:0]      rsp_class, rsp_node, rsp_Th, rsp_M;
    logic [VEC_W-1:0] rsp_X, rsp_W;
    logic             rsp_last, rsp_err;

    gam_mem_initiator dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_class(req_class), .req_node(req_node), .req_fields(req_fields),
        .req_X(req_X), .req_W(req_W), .req_Th(req_Th), .req_M(req_M),
        .mem_class(mem_class), .mem_node(mem_node), .mem_Th(mem_Th), .mem_M(mem_M),
        .mem_X(mem_X), .mem_W(mem_W),
        .mem_X_c(mem_X_c), .mem_C_c(mem_C_c), .mem_W_c(mem_W_c), .mem_T_c(mem_T_c),
        .mem_M_c(mem_M_c), .mem_RD_WR(mem_RD_WR),
        .mem_rd_class(mem_rd_class), .mem_rd_Th(mem_rd_Th), .mem_rd_M(mem_rd_M),
        .mem_rd_X(mem_rd_X), .mem_rd_W(mem_rd_W),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_class(rsp_class), .rsp_node(rsp_node), .rsp_Th(rsp_Th), .rsp_M(rsp_M),
        .rsp_X(rsp_X), .rsp_W(rsp_W), .rsp_last(rsp_last), .rsp_err(rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural memory layer ----------------
    logic [31:0] mc  [NC][NN];
    logic [31:0] mth [NC][NN];
    logic [31:0] mm  [NC][NN];
    logic [31:0] mx  [NC][NN];
    logic [31:0] mw  [NC][NN];
    logic        in_rng;

    assign in_rng       = (mem_class < 32'(NC)) && (mem_node < 32'(NN));
    assign mem_rd_class = in_rng ? mc [mem_class[3:0]][mem_node[4:0]] : 32'd0;
    assign mem_rd_Th    = in_rng ? mth[mem_class[3:0]][mem_node[4:0]] : 32'd0;
    assign mem_rd_M     = in_rng ? mm [mem_class[3:0]][mem_node[4:0]] : 32'd0;
    assign mem_rd_X     = in_rng ? mx [mem_class[3:0]][mem_node[4:0]] : 32'd0;
    assign mem_rd_W     = in_rng ? mw [mem_class[3:0]][mem_node[4:0]] : 32'd0;

    always @(posedge clk) begin
        if (mem_RD_WR && in_rng) begin
            if (mem_C_c) mc [mem_class[3:0]][mem_node[4:0]] <= mem_class;
            if (mem_T_c) mth[mem_class[3:0]][mem_node[4:0]] <= mem_Th;
            if (mem_M_c) mm [mem_class[3:0]][mem_node[4:0]] <= mem_M;
            if (mem_X_c) mx [mem_class[3:0]][mem_node[4:0]] <= mem_X;
            if (mem_W_c) mw [mem_class[3:0]][mem_node[4:0]] <= mem_W;
        end
    end

    // ---------------- counters, monitor, scoreboard ----------------
    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int strobe_cnt = 0;
    int wr_cnt = 0;
    int lat = 0;
    bit lat_seen = 1'b0;
    bit toggle_rdy = 1'b0;
    logic [31:0] last_wr_m = 32'd0;

    typedef struct {
        logic [31:0] cls;
        logic [31:0] node;
        logic [31:0] th;
        logic [31:0] m;
        logic [31:0] x;
        logic [31:0] w;
        logic        last;
        logic        err;
    } exp_t;
    exp_t q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] cls, input logic [31:0] node,
                            input logic [31:0] th, input logic [31:0] m,
                            input logic [31:0] x, input logic [31:0] w,
                            input logic last, input logic err);
        exp_t e;
        e.cls = cls; e.node = node; e.th = th; e.m = m;
        e.x = x; e.w = w; e.last = last; e.err = err;
        q.push_back(e);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (toggle_rdy) rsp_ready = ~rsp_ready;
        else            rsp_ready = 1'b1;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_X_c | mem_C_c | mem_W_c | mem_T_c | mem_M_c) strobe_cnt++;
            if (mem_RD_WR && (mem_X_c | mem_C_c | mem_W_c | mem_T_c | mem_M_c)) wr_cnt++;
            if (mem_RD_WR && mem_M_c) last_wr_m = mem_M;
            if (rsp_valid && !lat_seen) begin
                lat = cyc - acc_cyc + 1;
                lat_seen = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && rsp_valid && rsp_ready) begin
            if (q.size() == 0) begin
                check("unexpected_rsp", 64'(1), 64'(0));
            end else begin
                e = q.pop_front();
                check("rsp_err",   64'(rsp_err),   64'(e.err));
                check("rsp_last",  64'(rsp_last),  64'(e.last));
                check("rsp_node",  64'(rsp_node),  64'(e.node));
                check("rsp_class", 64'(rsp_class), 64'(e.cls));
                check("rsp_Th",    64'(rsp_Th),    64'(e.th));
                check("rsp_M",     64'(rsp_M),     64'(e.m));
                check("rsp_X",     64'(rsp_X),     64'(e.x));
                check("rsp_W",     64'(rsp_W),     64'(e.w));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_req(input logic [1:0] op, input logic [31:0] cls, input logic [31:0] node,
                            input logic [4:0] f, input logic [31:0] x, input logic [31:0] w,
                            input logic [31:0] th, input logic [31:0] m);
        bit got;
        got = 1'b0;
        @(posedge clk); #1;
        strobe_cnt = 0; wr_cnt = 0; lat_seen = 1'b0; lat = -1;
        req_op = op; req_class = cls; req_node = node; req_fields = f;
        req_X = x; req_W = w; req_Th = th; req_M = m;
        req_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (req_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check("req_ready_timeout", 64'(0), 64'(1));
        @(posedge clk); #1;
        acc_cyc = cyc;
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 2000; i++) begin
            if (q.size() == 0) break;
            @(negedge clk);
        end
        check(tag, 64'(q.size()), 64'(0));
        @(posedge clk); #1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0; req_op = 2'd0; req_class = 32'd0; req_node = 32'd0;
        req_fields = 5'd0; req_X = 32'd0; req_W = 32'd0; req_Th = 32'd0; req_M = 32'd0;
        for (int c = 0; c < NC; c++) begin
            for (int n = 0; n < NN; n++) begin
                mc[c][n]  <= 32'd0;
                mth[c][n] <= (c == 2) ? 32'(100 + n) : 32'd0;
                mm[c][n]  <= (c == 2) ? 32'(200 + n) : 32'd0;
                mx[c][n]  <= 32'd0;
                mw[c][n]  <= 32'd0;
            end
        end
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 64'(req_ready), 64'(1));
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_rsp_last",  64'(rsp_last),  64'(0));
        check("rst_rsp_err",   64'(rsp_err),   64'(0));
        check("rst_strobes",   64'({mem_X_c, mem_C_c, mem_W_c, mem_T_c, mem_M_c}), 64'(0));
        check("rst_rd_wr",     64'(mem_RD_WR), 64'(0));
        check("rst_mem_node",  64'(mem_node),  64'(0));
        check("rst_rsp_M",     64'(rsp_M),     64'(0));
        rst_n = 1'b1;

        // WRITE class 3 node 5, T and M only
        push_exp(32'd0, 32'd5, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        send_req(2'd1, 32'd3, 32'd5, 5'b00011, 32'hAAAA_0001, 32'hBBBB_0001, 32'd40, 32'd7);
        wait_done("wr_done");
        check("wr_strobe_cycles", 64'(strobe_cnt), 64'(1));
        check("wr_write_cycles",  64'(wr_cnt),     64'(1));
        check("wr_latency",       64'(lat),        64'(2));
        check("wr_mem_M",  64'(mm[3][5]),  64'(7));
        check("wr_mem_Th", 64'(mth[3][5]), 64'(40));
        check("wr_mem_X_untouched", 64'(mx[3][5]), 64'(0));

        // READ back with the same mask
        push_exp(32'd0, 32'd5, 32'd40, 32'd7, 32'd0, 32'd0, 1'b1, 1'b0);
        send_req(2'd0, 32'd3, 32'd5, 5'b00011, 32'd0, 32'd0, 32'd0, 32'd0);
        wait_done("rd_done");
        check("rd_strobe_cycles", 64'(strobe_cnt), 64'(1));
        check("rd_write_cycles",  64'(wr_cnt),     64'(0));
        check("rd_latency",       64'(lat),        64'(2));

        // INC_M on M=7, mask ignored
        push_exp(32'd0, 32'd5, 32'd0, 32'd8, 32'd0, 32'd0, 1'b1, 1'b0);
        send_req(2'd3, 32'd3, 32'd5, 5'b11110, 32'd0, 32'd0, 32'd0, 32'd0);
        wait_done("inc_done");
        check("inc_strobe_cycles", 64'(strobe_cnt), 64'(2));
        check("inc_write_cycles",  64'(wr_cnt),     64'(1));
        check("inc_written_M",     64'(last_wr_m),  64'(8));
        check("inc_latency",       64'(lat),        64'(3));
        check("inc_mem_Th_kept",   64'(mth[3][5]),  64'(40));

        // INC_M saturates at M_MAX
        push_exp(32'd0, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        send_req(2'd1, 32'd4, 32'd1, 5'b00001, 32'd0, 32'd0, 32'd0, MMAX);
        wait_done("wr_max_done");
        push_exp(32'd0, 32'd1, 32'd0, MMAX, 32'd0, 32'd0, 1'b1, 1'b0);
        send_req(2'd3, 32'd4, 32'd1, 5'b00000, 32'd0, 32'd0, 32'd0, 32'd0);
        wait_done("inc_sat_done");
        check("inc_sat_written_M", 64'(last_wr_m), 64'(MMAX));
        check("inc_sat_mem_M",     64'(mm[4][1]),  64'(MMAX));

        // node out of range -> error, no strobes
        push_exp(32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b1);
        send_req(2'd0, 32'd3, 32'd32, 5'b11111, 32'd0, 32'd0, 32'd0, 32'd0);
        wait_done("err_node_done");
        check("err_node_strobes", 64'(strobe_cnt), 64'(0));
        check("err_node_latency", 64'(lat),        64'(1));

        // class out of range -> error
        push_exp(32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b1);
        send_req(2'd1, 32'd16, 32'd0, 5'b11111, 32'd1, 32'd1, 32'd1, 32'd1);
        wait_done("err_class_done");
        check("err_class_strobes", 64'(strobe_cnt), 64'(0));

        // full-mask write, then partial-mask reads
        push_exp(32'd0, 32'd9, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        send_req(2'd1, 32'd5, 32'd9, 5'b11111, 32'hDEAD_BEEF, 32'h1234_5678, 32'd11, 32'd22);
        wait_done("wr_full_done");
        push_exp(32'd0, 32'd9, 32'd0, 32'd0, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 1'b0);
        send_req(2'd0, 32'd5, 32'd9, 5'b10100, 32'd0, 32'd0, 32'd0, 32'd0);
        wait_done("rd_xw_done");
        push_exp(32'd5, 32'd9, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        send_req(2'd0, 32'd5, 32'd9, 5'b01000, 32'd0, 32'd0, 32'd0, 32'd0);
        wait_done("rd_c_done");

`ifdef GAM_MEM_SCAN_EN
        // SCAN class 2 with backpressure on every other cycle
        for (int n = 0; n < NN; n++) begin
            push_exp(32'd0, 32'(n), 32'(100 + n), 32'(200 + n), 32'd0, 32'd0, (n == NN - 1), 1'b0);
        end
        toggle_rdy = 1'b1;
        send_req(2'd2, 32'd2, 32'd77, 5'b00011, 32'd0, 32'd0, 32'd0, 32'd0);
        wait_done("scan_done");
        toggle_rdy = 1'b0;
        check("scan_strobe_cycles", 64'(strobe_cnt), 64'(NN));
        check("scan_write_cycles",  64'(wr_cnt),     64'(0));
`else
        // SCAN not compiled in -> single error response
        push_exp(32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b1);
        send_req(2'd2, 32'd2, 32'd0, 5'b00011, 32'd0, 32'd0, 32'd0, 32'd0);
        wait_done("scan_off_done");
        check("scan_off_strobes", 64'(strobe_cnt), 64'(0));
        check("scan_off_latency", 64'(lat),        64'(1));
`endif

        // reset during the RMW write cycle of an INC_M: nothing queued, no response allowed
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        send_req(2'd3, 32'd3, 32'd5, 5'b00001, 32'd0, 32'd0, 32'd0, 32'd0);
        @(negedge clk);
        @(negedge clk);
        check("rmw_phase_M_c",   64'(mem_M_c),   64'(1));
        check("rmw_phase_rd_wr", 64'(mem_RD_WR), 64'(1));
        #1 rst_n = 1'b0;
        #1;
        check("midrst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("midrst_strobes",   64'({mem_X_c, mem_C_c, mem_W_c, mem_T_c, mem_M_c}), 64'(0));
        check("midrst_rd_wr",     64'(mem_RD_WR), 64'(0));
        check("midrst_mem_M",     64'(mem_M),     64'(0));
        check("midrst_req_ready", 64'(req_ready), 64'(1));
        @(posedge clk); #1;
        check("midrst_no_write", 64'(mm[3][5]), 64'(8));
        rst_n = 1'b1;
        strobe_cnt = 0;
        repeat (6) @(negedge clk);
        check("postrst_rsp_valid", 64'(rsp_valid),  64'(0));
        check("postrst_req_ready", 64'(req_ready),  64'(1));
        check("postrst_strobes",   64'(strobe_cnt), 64'(0));

        // normal operation resumes
        push_exp(32'd0, 32'd5, 32'd0, 32'd8, 32'd0, 32'd0, 1'b1, 1'b0);
        send_req(2'd0, 32'd3, 32'd5, 5'b00001, 32'd0, 32'd0, 32'd0, 32'd0);
        wait_done("final_rd_done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

endmodule
